// File: rtl/par_dot_engine.sv
// Sequential-address dot-product engine fed by a pair of synchronous-read operand RAMs.
// Optional macro SAT_EN: saturating accumulator plus sticky `sat` output.
module par_dot_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned ACC_W  = 2 * DATA_W + ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              rd,
  input  logic              act,
  output logic [ADDR_W-1:0] addr,
  output logic              ram_re,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic [ACC_W-1:0]  result,
  output logic              done,
  output logic              overrun
`ifdef SAT_EN
  ,
  output logic              sat
`endif
);

  localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CntOne   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                state_q;
  logic [ADDR_W:0]       issue_cnt_q;
  logic [ADDR_W:0]       acc_cnt_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  v1_q;
  logic                  v2_q;
  logic [DATA_W-1:0]     a_q;
  logic [DATA_W-1:0]     b_q;
  logic [ACC_W-1:0]      result_q;
  logic                  done_q;
  logic                  overrun_q;

  logic                  issue;
  logic                  acc_en;
  logic                  drop;
  logic [2*DATA_W-1:0]   prod;
  logic [ACC_W-1:0]      prod_ext;
  logic [ACC_W-1:0]      acc_next;

  // clr gates the strobe so a clear cycle never launches a RAM read.
  assign issue    = rd && !clr && !done_q && (issue_cnt_q < DepthCnt);
  assign acc_en   = v2_q && act && !done_q && (acc_cnt_q < DepthCnt);
  assign drop     = v2_q && !act && !done_q;
  assign prod     = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
  assign prod_ext = ACC_W'(prod);

`ifdef SAT_EN
  logic [ACC_W:0] acc_sum;
  logic           sat_q;
  assign acc_sum  = {1'b0, result_q} + {1'b0, prod_ext};
  assign acc_next = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
  assign sat      = sat_q;
`else
  assign acc_next = result_q + prod_ext;
`endif

  assign addr    = addr_q;
  assign ram_re  = issue;
  assign result  = result_q;
  assign done    = done_q;
  assign overrun = overrun_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      issue_cnt_q <= '0;
      acc_cnt_q   <= '0;
      addr_q      <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SAT_EN
      sat_q       <= 1'b0;
`endif
    end else if (clr) begin
      state_q     <= StIdle;
      issue_cnt_q <= '0;
      acc_cnt_q   <= '0;
      addr_q      <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      v1_q <= issue;
      v2_q <= v1_q;
      if (v1_q) begin
        a_q <= a_data;
        b_q <= b_data;
      end
      if (issue) begin
        addr_q      <= addr_q + AddrOne;
        issue_cnt_q <= issue_cnt_q + CntOne;
      end
      if (acc_en) begin
        result_q  <= acc_next;
        acc_cnt_q <= acc_cnt_q + CntOne;
`ifdef SAT_EN
        if (acc_sum[ACC_W]) sat_q <= 1'b1;
`endif
      end
      if (drop) overrun_q <= 1'b1;

      case (state_q)
        StIdle:  if (rd) state_q <= StRun;
        StRun:   if (issue_cnt_q == DepthCnt) state_q <= StDrain;
        StDrain: begin
          if (acc_cnt_q == DepthCnt) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else if (!v1_q && !v2_q) begin
            // Pipeline empty but pairs missing: finish as a short run.
            state_q   <= StDone;
            done_q    <= 1'b1;
            overrun_q <= 1'b1;
          end
        end
        StDone:  state_q <= StDone;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_par_dot_engine.sv
// Self-checking bench for par_dot_engine: directed runs plus randomized runs against
// an arithmetic dot-product model; a second ACC_W=16 instance exercises overflow.
module tb_par_dot_engine;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned ACC_W  = 20;
  localparam int unsigned SAT_W  = 16;

  logic              clk     = 1'b0;
  logic              reset   = 1'b1;
  logic              clr     = 1'b0;
  logic              rd      = 1'b0;
  logic              act     = 1'b0;
  logic [ADDR_W-1:0] addr;
  logic              ram_re;
  logic [DATA_W-1:0] a_data  = '0;
  logic [DATA_W-1:0] b_data  = '0;
  logic [ACC_W-1:0]  result;
  logic              done;
  logic              overrun;
  logic [ADDR_W-1:0] addr2;
  logic              ram_re2;
  logic [SAT_W-1:0]  result2;
  logic              done2;
  logic              overrun2;
`ifdef SAT_EN
  logic              sat;
  logic              sat2;
`endif

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic              rd_d1 = 1'b0;
  logic              rd_d2 = 1'b0;
  int                vectors = 0;
  int                errors  = 0;

  par_dot_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .clr(clr), .rd(rd), .act(act), .addr(addr), .ram_re(ram_re),
    .a_data(a_data), .b_data(b_data), .result(result), .done(done), .overrun(overrun)
`ifdef SAT_EN
    , .sat(sat)
`endif
  );

  // Narrow-accumulator instance, operands fixed at 0xFF.
  par_dot_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACC_W(SAT_W)) dut2 (
    .clk(clk), .reset(reset), .clr(clr), .rd(rd), .act(act), .addr(addr2), .ram_re(ram_re2),
    .a_data(8'hFF), .b_data(8'hFF), .result(result2), .done(done2), .overrun(overrun2)
`ifdef SAT_EN
    , .sat(sat2)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read operand RAMs.
  always @(posedge clk) begin
    if (ram_re) begin
      a_data <= mem_a[addr];
      b_data <= mem_b[addr];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: controller-style act is rd delayed by two cycles.
  task automatic cyc(input logic r, input logic kill, input logic c);
    @(posedge clk);
    #1;
    rd_d2 = rd_d1;
    rd_d1 = rd;
    rd    = r;
    clr   = c;
    act   = rd_d2 & ~kill;
    #1;
  endtask

  function automatic logic [ACC_W-1:0] model_sum(input int skip);
    longint s = 0;
    for (int i = 0; i < int'(DEPTH); i++)
      if (i != skip) s += longint'(mem_a[i]) * longint'(mem_b[i]);
    return s[ACC_W-1:0];
  endfunction

  task automatic clear_run();
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("clr_result", result, 0);
    chk("clr_done", done, 0);
    chk("clr_addr", addr, 0);
  endtask

  // Runs one job; rd drops for 3 cycles once gap_after+1 pairs are issued, and act is
  // forced low when pair drop_idx reaches the operand stage.
  task automatic do_run(input int gap_after, input int drop_idx, output int lat);
    int issued  = 0;
    int gap_left = 0;
    int kill_at = -1;
    int done_at = -1;
    int first   = -1;
    bit gap_used = 1'b0;
    lat = -1;
    for (int n = 0; n < 80; n++) begin
      logic r;
      logic exp_re;
      if (!gap_used && gap_after >= 0 && issued == gap_after + 1) begin
        gap_left = 3;
        gap_used = 1'b1;
      end
      r = (gap_left == 0);
      if (gap_left > 0) gap_left--;
      cyc(r, n == kill_at, 1'b0);
      exp_re = r && (issued < int'(DEPTH));
      chk("ram_re", ram_re, exp_re);
      if (issued < int'(DEPTH)) chk("addr", addr, issued);
      if (exp_re) begin
        if (first < 0) first = n;
        if (issued == drop_idx) kill_at = n + 2;
        if (issued == int'(DEPTH) - 1) done_at = n + 4;
        issued++;
      end
      chk("done", done, (done_at >= 0) && (n >= done_at));
      if (done_at >= 0 && n == done_at + 1) break;
    end
    chk("run_finished", done, 1);
    if (done_at >= 0) lat = done_at - first;
  endtask

  initial begin
    int lat;
    int gap;
    int drp;
    logic [SAT_W-1:0] sat_exp;

    #3 reset = 1'b0;
    #9;
    chk("rst_addr", addr, 0);
    chk("rst_ram_re", ram_re, 0);
    chk("rst_result", result, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b1;

    // Basic run: A[i]=i+1, B[i]=2.
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_a[i] = DATA_W'(i + 1);
      mem_b[i] = 8'd2;
    end
    clear_run();
    do_run(-1, -1, lat);
    chk("basic_latency", lat, 19);
    chk("basic_result", result, 272);
    chk("basic_model", result, model_sum(-1));
    chk("basic_overrun", overrun, 0);
`ifdef SAT_EN
    sat_exp = 16'hFFFF;
    chk("sat_flag", sat2, 1);
    chk("sat_flag_wide", sat, 0);
`else
    sat_exp = SAT_W'((DEPTH * 255 * 255) % 65536);  // 0xE010
`endif
    chk("narrow_result", result2, sat_exp);

    // Zero operands.
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_a[i] = 8'hFF;
      mem_b[i] = 8'h00;
    end
    clear_run();
    do_run(-1, -1, lat);
    chk("zero_result", result, 0);
    chk("zero_done", done, 1);

    // rd gap after addr 5, random operands.
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_a[i] = DATA_W'($urandom);
      mem_b[i] = DATA_W'($urandom);
    end
    clear_run();
    do_run(5, -1, lat);
    chk("gap_result", result, model_sum(-1));
    chk("gap_overrun", overrun, 0);

    // One dropped pair.
    clear_run();
    do_run(-1, 7, lat);
    chk("ovr_flag", overrun, 1);
    chk("ovr_result", result, model_sum(7));
    chk("ovr_done", done, 1);

    // clr coinciding with an accumulate.
    for (int i = 0; i < int'(DEPTH); i++) mem_a[i] = DATA_W'($urandom) | 8'h01;
    for (int i = 0; i < int'(DEPTH); i++) mem_b[i] = DATA_W'($urandom) | 8'h01;
    clear_run();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("pre_clr_nonzero", result != 0, 1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("clr_cycle_ram_re", ram_re, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("clracc_result", result, 0);
    chk("clracc_addr", addr, 0);
    chk("clracc_done", done, 0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("clracc_late_result", result, 0);
    chk("clracc_overrun", overrun, 0);

    // Asynchronous reset mid-run.
    clear_run();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    rd    = 1'b0;
    act   = 1'b0;
    rd_d1 = 1'b0;
    rd_d2 = 1'b0;
    #1;
    chk("arst_addr", addr, 0);
    chk("arst_ram_re", ram_re, 0);
    chk("arst_result", result, 0);
    chk("arst_done", done, 0);
    chk("arst_overrun", overrun, 0);
    #10 reset = 1'b1;

    // Randomized runs.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_a[i] = DATA_W'($urandom);
        mem_b[i] = DATA_W'($urandom);
      end
      gap = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 13)) : -1;
      drp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, DEPTH - 1)) : -1;
      clear_run();
      do_run(gap, drp, lat);
      chk("rand_result", result, model_sum(drp));
      chk("rand_overrun", overrun, drp >= 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
